iq_window_framer: RTL and testbench

IQ_WINDOW_FRAMER -- requirements
Module: iq_window_framer

---
 rtl/iq_window_framer.sv | 98 +++++++++
 tb/tb_iq_window_framer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iq_window_framer.sv
// Joins I and Q sample streams into {Q, I} words and frames them into
// fixed-length CNN windows behind a 2-entry skid buffer.
module iq_window_framer #(
    parameter int DATA_W     = 16,
    parameter int WINDOW_LEN = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [DATA_W-1:0]   s_axis_i_tdata,
    input  logic                s_axis_i_tvalid,
    output logic                s_axis_i_tready,
    input  logic                s_axis_i_tlast,
    input  logic [DATA_W-1:0]   s_axis_q_tdata,
    input  logic                s_axis_q_tvalid,
    output logic                s_axis_q_tready,
    input  logic                s_axis_q_tlast,
    output logic [2*DATA_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,
    output logic [15:0]         window_count,
    output logic                tlast_mismatch
);

    localparam int IDX_W  = $clog2(WINDOW_LEN);
    localparam int WORD_W = 2 * DATA_W + 2;

    logic [1:0]        count;
    logic              active;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] head;
    logic [WORD_W-1:0] skid;
    logic [WORD_W-1:0] new_word;
    logic              join_ok;
    logic              pop;
    logic              win_end;
    logic              frame_end;

    // active holds off joins on the first edge after reset release
    assign join_ok = active & s_axis_i_tvalid & s_axis_q_tvalid
                   & (count != 2'd2);

    assign s_axis_i_tready = join_ok;
    assign s_axis_q_tready = join_ok;

    assign m_axis_tvalid = (count != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;

    assign win_end   = (idx == IDX_W'(WINDOW_LEN - 1));
    assign frame_end = win_end | s_axis_i_tlast | s_axis_q_tlast;
    assign new_word  = {(idx == '0), frame_end,
                        s_axis_q_tdata, s_axis_i_tdata};

    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = head;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            active <= 1'b0;
            count  <= 2'd0;
            head   <= '0;
            skid   <= '0;
        end else begin
            active <= 1'b1;
            count  <= count + {1'b0, join_ok} - {1'b0, pop};
            // head is the output register; skid only fills on a stall
            if (join_ok && (count == 2'd0 || pop)) begin
                head <= new_word;
            end else if (pop && count == 2'd2) begin
                head <= skid;
            end
            if (join_ok && count == 2'd1 && !pop) begin
                skid <= new_word;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx            <= '0;
            tlast_mismatch <= 1'b0;
        end else if (join_ok) begin
            idx <= frame_end ? '0 : idx + 1'b1;
            if (s_axis_i_tlast != s_axis_q_tlast) begin
                tlast_mismatch <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            window_count <= 16'd0;
        end else if (pop && m_axis_tlast) begin
            window_count <= window_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_iq_window_framer.sv
// Randomized bench for iq_window_framer against a queue-based model
// of the joined word stream, window framing and counters.
module tb_iq_window_framer;

    localparam int DW = 16;
    localparam int WL = 8;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] i_d = '0, q_d = '0;
    logic          i_v = 1'b0, q_v = 1'b0, i_l = 1'b0, q_l = 1'b0;
    logic          i_r, q_r;
    logic [2*DW-1:0] m_d;
    logic          m_v, m_l, m_u;
    logic          m_r = 1'b0;
    logic [15:0]   wcnt;
    logic          mism;

    int n_cmp = 0;
    int n_err = 0;

    logic [2*DW+1:0] exp_q[$];
    int  m_idx = 0;
    bit  m_mism = 0;
    int  m_wcnt = 0;
    bit  m_act = 0;
    bit  acc = 0;

    always #5 clock = ~clock;

    iq_window_framer #(.DATA_W(DW), .WINDOW_LEN(WL)) dut (
        .clock(clock),
        .resetn(resetn),
        .s_axis_i_tdata(i_d),
        .s_axis_i_tvalid(i_v),
        .s_axis_i_tready(i_r),
        .s_axis_i_tlast(i_l),
        .s_axis_q_tdata(q_d),
        .s_axis_q_tvalid(q_v),
        .s_axis_q_tready(q_r),
        .s_axis_q_tlast(q_l),
        .m_axis_tdata(m_d),
        .m_axis_tvalid(m_v),
        .m_axis_tready(m_r),
        .m_axis_tlast(m_l),
        .m_axis_tuser(m_u),
        .window_count(wcnt),
        .tlast_mismatch(mism)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_idx  = 0;
        m_mism = 0;
        m_wcnt = 0;
        m_act  = 0;
        acc    = 0;
    endtask

    // Called at a negedge with inputs already driven; ends at next negedge.
    task automatic cycle();
        bit j, p, lst;
        logic [2*DW+1:0] w;
        #1;
        j = m_act && i_v && q_v && (exp_q.size() < 2);
        chk("i_tready", i_r, j);
        chk("q_tready", q_r, j);
        chk("m_tvalid", m_v, exp_q.size() > 0);
        if (exp_q.size() > 0) chk("m_word", {m_u, m_l, m_d}, exp_q[0]);
        chk("window_count", wcnt, 64'(m_wcnt & 'hffff));
        chk("tlast_mismatch", mism, m_mism);
        p = (exp_q.size() > 0) && m_r;
        if (p) begin
            w = exp_q.pop_front();
            if (w[2*DW]) m_wcnt++;
        end
        if (j) begin
            lst = (m_idx == WL - 1) || i_l || q_l;
            exp_q.push_back({m_idx == 0, lst, q_d, i_d});
            m_idx = lst ? 0 : m_idx + 1;
            if (i_l != q_l) m_mism = 1;
        end
        m_act = resetn;
        acc   = j;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rand_drive(input int vpct, input int rpct,
                              input bit bad_last);
        bit l;
        if (acc) begin
            i_v = 0;
            q_v = 0;
            l   = ($urandom_range(7) == 0);
            i_d = DW'($urandom);
            q_d = DW'($urandom);
            i_l = l;
            q_l = bad_last ? ~l : l;
        end
        if (!i_v) i_v = ($urandom_range(99) < vpct);
        if (!q_v) q_v = ($urandom_range(99) < vpct);
        m_r = ($urandom_range(99) < rpct);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        cycle();
        resetn = 1'b1;
        cycle();

        // counting pattern, continuous flow
        i_v = 1; q_v = 1; m_r = 1; i_l = 0; q_l = 0;
        for (int n = 0; n < 16; n++) begin
            i_d = DW'(n);
            q_d = DW'(16'h8000 + n);
            cycle();
        end
        i_v = 0; q_v = 0;
        repeat (3) cycle();
        chk("flow_window_count", wcnt, 2);

        // I waits for Q without being consumed
        i_v = 1; i_d = 16'h1234; q_v = 0;
        repeat (5) cycle();
        q_v = 1; q_d = 16'habcd;
        cycle();
        i_v = 0; q_v = 0;
        repeat (2) cycle();

        // downstream stall fills the skid buffer, then drains in order
        i_v = 1; q_v = 1; m_r = 0;
        for (int k = 0; k < 12; k++) begin
            if (acc) begin
                i_d = i_d + 1'b1;
                q_d = q_d + 1'b1;
            end
            if (k == 6) m_r = 1;
            cycle();
        end
        i_v = 0; q_v = 0;
        repeat (3) cycle();

        // early frame end on third sample of a fresh window
        for (int k = 0; k < 5; k++) begin
            i_v = 1; q_v = 1;
            i_d = DW'(16'h0300 + k);
            q_d = DW'(16'h0400 + k);
            i_l = (k == 2); q_l = (k == 2);
            cycle();
        end
        i_v = 0; q_v = 0; i_l = 0; q_l = 0;
        repeat (3) cycle();
        chk("early_end_mismatch", mism, 0);

        acc = 1;
        for (int k = 0; k < 400; k++) begin
            rand_drive(70, 70, 0);
            cycle();
        end

        // tlast disagreement sets the sticky flag
        i_v = 1; q_v = 1; m_r = 1;
        i_l = 1; q_l = 0;
        cycle();
        i_l = 0;
        acc = 1;
        for (int k = 0; k < 100; k++) begin
            while (!acc) begin
                rand_drive(80, 80, 0);
                cycle();
            end
            rand_drive(80, 80, 0);
            cycle();
        end
        chk("sticky_mismatch", mism, 1);

        // reset with the skid buffer full
        i_v = 1; q_v = 1; m_r = 0; i_l = 0; q_l = 0;
        repeat (4) cycle();
        resetn = 1'b0;
        #1;
        chk("async_tvalid", m_v, 0);
        chk("async_wcount", wcnt, 0);
        chk("async_mismatch", mism, 0);
        model_reset();
        i_v = 0; q_v = 0;
        cycle();
        resetn = 1'b1;
        i_v = 1; q_v = 1; m_r = 1;
        i_d = 16'h5555; q_d = 16'haaaa;
        cycle();
        cycle();
        chk("post_reset_tuser", m_u, 1);
        i_v = 0; q_v = 0;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
